// File: rtl/io_write_fifo_if.sv
// -----------------------------------------------------------------------------
// io_write_fifo_if
// Downstream stream handshake between the I/O write FIFO and its consumer.
//
// Signals
//   m_valid  head entry available (driven by the FIFO)
//   m_ready  consumer accepts the head entry on this clock edge
//   m_addr   I/O port address of the head entry
//   m_data   data byte of the head entry
//
// Modports
//   master   FIFO side: drives m_valid/m_addr/m_data, samples m_ready
//   slave    consumer side: samples m_valid/m_addr/m_data, drives m_ready
// -----------------------------------------------------------------------------
interface io_write_fifo_if;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_addr;
    logic [7:0] m_data;

    modport master (output m_valid, output m_addr, output m_data, input m_ready);
    modport slave  (input m_valid, input m_addr, input m_data, output m_ready);
endinterface

// File: rtl/io_write_fifo.sv
// -----------------------------------------------------------------------------
// io_write_fifo
// Captures CPU I/O port writes (ports 0x0-0xD) into a first-word-fall-through
// FIFO and presents them to a downstream consumer. Port 0xE reads back status,
// port 0xF reads back the most recent accepted byte; a write to 0xF clears the
// sticky overflow flag.
//
// Parameters
//   DEPTH     FIFO entries, power of two in 2..16
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   io_addr   CPU I/O port address
//   io_data   CPU I/O data bus (bidirectional, high-Z unless a status read)
//   io_we     CPU write strobe, may stay high for several cycles
//   io_oe     CPU read enable
//   m         downstream stream (io_write_fifo_if.master)
//   count     occupancy, 0..DEPTH
//   overflow  sticky: a write was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module io_write_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             io_addr,
    inout  wire  [7:0]             io_data,
    input  logic                   io_we,
    input  logic                   io_oe,
    io_write_fifo_if.master        m,
    output logic [4:0]             count,
    output logic                   overflow
);
    localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C     = 5'(DEPTH);
    localparam logic [3:0] ADDR_LAST   = 4'hD;   // highest port that is queued
    localparam logic [3:0] ADDR_STATUS = 4'hE;
    localparam logic [3:0] ADDR_CTRL   = 4'hF;

    logic [11:0]   mem [DEPTH];
    logic [11:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          io_we_q;
    logic [7:0]    last_push;

    logic          we_event;
    logic          push_req;
    logic          clr_req;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;

    logic          rd_en;
    logic [7:0]    rd_value;

    // One event per strobe: only the rising edge of io_we counts.
    assign we_event = io_we && !io_we_q;
    assign push_req = we_event && (io_addr <= ADDR_LAST);
    assign clr_req  = we_event && (io_addr == ADDR_CTRL);

    assign full  = (count == DEPTH_C);
    assign empty = (count == 5'd0);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when the consumer drains the head on the same edge.
    assign pop  = !empty && m.m_ready;
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the pre-edge values of their neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            io_we_q   <= 1'b1;   // a strobe held through reset is not an event
            last_push <= 8'h00;
        end else begin
            io_we_q <= io_we;

            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                last_push <= io_data;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase

            // A 0xF write is never a push, so clear and drop cannot coincide.
            if (clr_req) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; an entry is only visible after it
    // has been written, and the head output is gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= {io_addr, io_data};
        end
    end

    assign head      = mem[rd_ptr];
    assign m.m_valid = !empty;
    assign m.m_addr  = empty ? 4'h0  : head[11:8];
    assign m.m_data  = empty ? 8'h00 : head[7:0];

    // NOTE: both outputs get a default before the case so no path through
    // this block can leave them unassigned and infer a latch.
    always_comb begin
        rd_en    = 1'b0;
        rd_value = 8'h00;
        if (io_oe) begin
            case (io_addr)
                ADDR_STATUS: begin
                    rd_en    = 1'b1;
                    rd_value = {overflow, full, empty, count};
                end
                ADDR_CTRL: begin
                    rd_en    = 1'b1;
                    rd_value = last_push;
                end
                default: begin
                    rd_en    = 1'b0;
                    rd_value = 8'h00;
                end
            endcase
        end
    end

    assign io_data = rd_en ? rd_value : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_io_write_fifo.sv
// -----------------------------------------------------------------------------
// tb_io_write_fifo
// Directed scenarios followed by a randomized phase for io_write_fifo. A
// queue-based reference model of the FIFO's externally visible behaviour is
// advanced on every rising edge and compared against the DUT after the edge.
// -----------------------------------------------------------------------------
module tb_io_write_fifo;
    localparam int DEPTH = 8;

    typedef logic [11:0] entry_t;   // {port address, data byte}

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] io_addr;
    logic       io_we;
    logic       io_oe;
    logic [7:0] tb_data;
    logic       tb_drive;
    wire  [7:0] io_data;
    logic [4:0] count;
    logic       overflow;

    assign io_data = tb_drive ? tb_data : 8'bzzzz_zzzz;

    io_write_fifo_if m_if ();

    io_write_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .io_addr  (io_addr),
        .io_data  (io_data),
        .io_we    (io_we),
        .io_oe    (io_oe),
        .m        (m_if.master),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    entry_t     mq[$];       // entries held by the FIFO, head first
    entry_t     exp_log[$];  // entries the model says were handed downstream
    entry_t     act_log[$];  // entries observed leaving the DUT
    entry_t     want[$];     // directed expectation for a drain
    bit         m_ovf;
    logic [7:0] m_last;
    bit         m_we_prev;

    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {m_ovf, (mq.size() == DEPTH), (mq.size() == 0), 5'(mq.size())};
    endfunction

    // Behavioural rules applied to the inputs present at a rising edge.
    function automatic void model_step();
        bit ev;
        bit was_full;
        bit do_pop;
        if (reset) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_last    = 8'h00;
            m_we_prev = 1'b1;
            return;
        end
        ev       = io_we && !m_we_prev;
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && m_if.m_ready;
        if (do_pop) exp_log.push_back(mq.pop_front());
        if (ev && io_addr <= 4'hD) begin
            if (was_full && !do_pop) begin
                m_ovf = 1'b1;
            end else begin
                mq.push_back({io_addr, tb_data});
                m_last = tb_data;
            end
        end
        if (ev && io_addr == 4'hF) m_ovf = 1'b0;
        m_we_prev = io_we;
    endfunction

    task automatic check_outputs();
        check("m_valid", 32'(m_if.m_valid), 32'(mq.size() != 0));
        check("count", 32'(count), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0)
            check("head", 32'({m_if.m_addr, m_if.m_data}), 32'(mq[0]));
        else
            check("head_idle", 32'({m_if.m_addr, m_if.m_data}), 32'(0));
    endtask

    // One clock: log handshakes before the edge, advance model, compare after.
    task automatic tick();
        bit     stall;
        entry_t held;
        if (m_if.m_valid && m_if.m_ready && !reset)
            act_log.push_back({m_if.m_addr, m_if.m_data});
        stall = m_if.m_valid && !m_if.m_ready && !reset;
        held  = {m_if.m_addr, m_if.m_data};
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (stall) begin
            check("stall_valid", 32'(m_if.m_valid), 32'(1));
            check("stall_head", 32'({m_if.m_addr, m_if.m_data}), 32'(held));
        end
    endtask

    task automatic read_port(input logic [3:0] a, input logic [7:0] exp, input string tag);
        logic [3:0] sa;
        logic       sd;
        sa = io_addr;
        sd = tb_drive;
        io_addr  = a;
        tb_drive = 1'b0;
        io_oe    = 1'b1;
        #1;
        check(tag, 32'(io_data), 32'(exp));
        io_oe    = 1'b0;
        io_addr  = sa;
        tb_drive = sd;
        #1;
    endtask

    // The bus must be released for any address other than 0xE/0xF.
    task automatic hiz_check(input logic [3:0] a, input logic oe, input string tag);
        logic [3:0] sa;
        logic       sd;
        logic [7:0] sdat;
        sa = io_addr;
        sd = tb_drive;
        sdat = tb_data;
        io_addr  = a;
        io_oe    = oe;
        tb_data  = 8'h5A;
        tb_drive = 1'b1;
        #1;
        check(tag, 32'(io_data), 32'(8'h5A));
        io_oe    = 1'b0;
        io_addr  = sa;
        tb_data  = sdat;
        tb_drive = sd;
        #1;
    endtask

    task automatic write_strobe(input logic [3:0] a, input logic [7:0] d, input int len);
        io_addr  = a;
        tb_data  = d;
        tb_drive = 1'b1;
        io_we    = 1'b1;
        repeat (len) tick();
        io_we    = 1'b0;
        tb_drive = 1'b0;
        tick();
    endtask

    task automatic drain_all();
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && count != 5'd0; i++) tick();
        check("drain_empty", 32'(count), 32'(0));
        m_if.m_ready = 1'b0;
    endtask

    task automatic check_drain(input string tag);
        check({tag, "_len"}, 32'(act_log.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < act_log.size(); i++)
            check(tag, 32'(act_log[i]), 32'(want[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        io_addr      = 4'h0;
        io_we        = 1'b0;
        io_oe        = 1'b0;
        tb_data      = 8'h00;
        tb_drive     = 1'b0;
        m_if.m_ready = 1'b0;
        m_ovf        = 1'b0;
        m_last       = 8'h00;
        m_we_prev    = 1'b1;

        // Reset state
        tick();
        tick();
        read_port(4'hF, 8'h00, "reset_last_push");
        read_port(4'hE, 8'h20, "reset_status");
        hiz_check(4'h3, 1'b1, "hiz_other_addr");
        hiz_check(4'hE, 1'b0, "hiz_oe_low");
        reset = 1'b0;
        tick();

        // Blink pattern with the consumer always ready
        act_log.delete();
        m_if.m_ready = 1'b1;
        write_strobe(4'h0, 8'h01, 1);
        write_strobe(4'h0, 8'h00, 1);
        repeat (3) tick();
        want = '{12'h001, 12'h000};
        check_drain("blink");
        check("blink_count", 32'(count), 32'(0));

        // Long strobe yields a single push
        m_if.m_ready = 1'b0;
        write_strobe(4'h3, 8'h55, 5);
        check("hold_count", 32'(count), 32'(1));
        check("hold_head", 32'({m_if.m_addr, m_if.m_data}), 32'(12'h355));
        drain_all();

        // Nine writes into an eight-deep FIFO
        act_log.delete();
        for (int i = 0; i < 9; i++) write_strobe(4'h0, 8'(i), 1);
        check("ovf_count", 32'(count), 32'(8));
        check("ovf_flag", 32'(overflow), 32'(1));
        read_port(4'hE, 8'hC8, "ovf_status");
        read_port(4'hF, 8'h07, "ovf_last_push");
        drain_all();
        want.delete();
        for (int i = 0; i < 8; i++) want.push_back({4'h0, 8'(i)});
        check_drain("ovf_drain");
        write_strobe(4'hF, 8'h00, 1);
        check("ovf_cleared", 32'(overflow), 32'(0));
        read_port(4'hE, 8'h20, "cleared_status");
        write_strobe(4'hE, 8'h99, 1);
        check("port_e_no_push", 32'(count), 32'(0));

        // Push and pop on the same edge while full
        for (int i = 0; i < 8; i++) write_strobe(4'h2, 8'(8'h10 + i), 1);
        check("fullpp_pre_count", 32'(count), 32'(8));
        act_log.delete();
        io_addr      = 4'h2;
        tb_data      = 8'hAA;
        tb_drive     = 1'b1;
        io_we        = 1'b1;
        m_if.m_ready = 1'b1;
        tick();
        m_if.m_ready = 1'b0;
        io_we        = 1'b0;
        tb_drive     = 1'b0;
        tick();
        check("fullpp_count", 32'(count), 32'(8));
        check("fullpp_ovf", 32'(overflow), 32'(0));
        drain_all();
        want.delete();
        for (int i = 0; i < 8; i++) want.push_back({4'h2, 8'(8'h10 + i)});
        want.push_back(12'h2AA);
        check_drain("fullpp_drain");

        // Fibonacci stream with the consumer toggling every cycle
        act_log.delete();
        want.delete();
        begin
            int fa;
            int fb;
            int ft;
            fa = 0;
            fb = 1;
            for (int i = 0; i < 8; i++) begin
                want.push_back({4'h1, 8'(fa)});
                io_addr      = 4'h1;
                tb_data      = 8'(fa);
                tb_drive     = 1'b1;
                io_we        = 1'b1;
                m_if.m_ready = ~m_if.m_ready;
                tick();
                io_we        = 1'b0;
                tb_drive     = 1'b0;
                m_if.m_ready = ~m_if.m_ready;
                tick();
                ft = fa + fb;
                fa = fb;
                fb = ft;
            end
        end
        for (int i = 0; i < 40 && count != 5'd0; i++) begin
            m_if.m_ready = ~m_if.m_ready;
            tick();
        end
        m_if.m_ready = 1'b0;
        check_drain("fib");

        // Reset while holding entries and a raised strobe
        for (int i = 0; i < 5; i++) write_strobe(4'h6, 8'(8'h30 + i), 1);
        check("rst_pre_count", 32'(count), 32'(5));
        io_addr  = 4'h4;
        tb_data  = 8'h77;
        tb_drive = 1'b1;
        io_we    = 1'b1;
        reset    = 1'b1;
        tick();
        check("rst_count", 32'(count), 32'(0));
        check("rst_valid", 32'(m_if.m_valid), 32'(0));
        reset = 1'b0;
        repeat (3) tick();
        check("rst_held_strobe", 32'(count), 32'(0));
        read_port(4'hF, 8'h00, "rst_last_push");
        io_we = 1'b0;
        tick();
        io_we = 1'b1;
        tick();
        check("rst_new_strobe", 32'({count, m_if.m_addr, m_if.m_data}), 32'({5'd1, 12'h477}));
        io_we    = 1'b0;
        tb_drive = 1'b0;
        tick();
        drain_all();

        // Randomized traffic against the reference model
        act_log.delete();
        exp_log.delete();
        for (int c = 0; c < 800; c++) begin
            io_we    = ($urandom_range(0, 2) != 0);
            io_addr  = ($urandom_range(0, 7) == 0) ? 4'(14 + $urandom_range(0, 1))
                                                   : 4'($urandom_range(0, 13));
            tb_data  = 8'($urandom);
            tb_drive = 1'b1;
            m_if.m_ready = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 249) == 0);
            tick();
            if ($urandom_range(0, 3) == 0) begin
                read_port(4'hE, exp_status(), "rand_status");
                read_port(4'hF, m_last, "rand_last_push");
            end
        end
        reset    = 1'b0;
        io_we    = 1'b0;
        tb_drive = 1'b0;
        tick();
        drain_all();
        check("rand_log_len", 32'(act_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < act_log.size() && i < exp_log.size(); i++)
            check("rand_log", 32'(act_log[i]), 32'(exp_log[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
